// File: rtl/vga_text_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | vga_text_pkg : constants and FSM encoding for the VGA text writer    |
// | Build macro VGA_TEXT_CLEAR_ON_RESET_EN adds the CLR_ALL state.       |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
package vga_text_pkg;

    localparam int COLS_DEF = 80;
    localparam int ROWS_DEF = 30;

    localparam logic [7:0] ASC_BS    = 8'h08;
    localparam logic [7:0] ASC_LF    = 8'h0A;
    localparam logic [7:0] ASC_CR    = 8'h0D;
    localparam logic [7:0] ASC_SPACE = 8'h20;

`ifdef VGA_TEXT_CLEAR_ON_RESET_EN
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_PUT       = 3'd1,
        ST_SCROLL_RD = 3'd2,
        ST_SCROLL_WR = 3'd3,
        ST_CLR_LINE  = 3'd4,
        ST_CLR_ALL   = 3'd5
    } state_t;
`else
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_PUT       = 3'd1,
        ST_SCROLL_RD = 3'd2,
        ST_SCROLL_WR = 3'd3,
        ST_CLR_LINE  = 3'd4
    } state_t;
`endif

    // Cursor action carried from byte acceptance to the end of the PUT cycle.
    typedef enum logic [1:0] {
        OP_NONE = 2'd0,
        OP_INC  = 2'd1,
        OP_LF   = 2'd2,
        OP_CR   = 2'd3
    } op_t;

    function automatic logic is_printable(input logic [7:0] c);
        return (c >= 8'h20) && (c <= 8'h7E);
    endfunction

endpackage
`default_nettype wire

// File: rtl/vga_text_cursor.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | vga_text_cursor : row/col/linear-address cursor with scroll request  |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module vga_text_cursor #(
    parameter int COLS   = 80,
    parameter int ROWS   = 30,
    parameter int ADDR_W = 12
) (
    input  logic              pclk,
    input  logic              rst,
    input  logic              i_inc,
    input  logic              i_dec,
    input  logic              i_cr,
    input  logic              i_lf,
    input  logic              i_home,
    output logic [4:0]        o_row,
    output logic [6:0]        o_col,
    output logic [ADDR_W-1:0] o_addr,
    output logic [ADDR_W-1:0] o_dec_addr,
    output logic              o_scroll_req
);

    localparam logic [4:0]        c_LAST_ROW      = 5'(ROWS - 1);
    localparam logic [6:0]        c_LAST_COL      = 7'(COLS - 1);
    localparam logic [ADDR_W-1:0] c_LAST_ROW_ADDR = ADDR_W'((ROWS - 1) * COLS);
    localparam logic [ADDR_W-1:0] c_COLS_A        = ADDR_W'(COLS);

    logic [4:0]        r_row;
    logic [6:0]        r_col;
    logic [ADDR_W-1:0] r_addr;

    logic              w_last_col;
    logic              w_last_row;
    logic [ADDR_W-1:0] w_line_start;

    assign w_last_col   = (r_col == c_LAST_COL);
    assign w_last_row   = (r_row == c_LAST_ROW);
    assign w_line_start = r_addr - ADDR_W'(r_col);

    assign o_row        = r_row;
    assign o_col        = r_col;
    assign o_addr       = r_addr;
    assign o_dec_addr   = r_addr - ADDR_W'(1);
    assign o_scroll_req = w_last_row && (i_lf || (i_inc && w_last_col));

    // The linear address tracks row*COLS+col by increments only.
    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            r_row  <= '0;
            r_col  <= '0;
            r_addr <= '0;
        end else if (i_home) begin
            r_row  <= '0;
            r_col  <= '0;
            r_addr <= '0;
        end else if (i_inc) begin
            if (!w_last_col) begin
                r_col  <= r_col + 7'd1;
                r_addr <= r_addr + ADDR_W'(1);
            end else begin
                r_col <= '0;
                if (!w_last_row) begin
                    r_row  <= r_row + 5'd1;
                    r_addr <= r_addr + ADDR_W'(1);
                end else begin
                    r_addr <= c_LAST_ROW_ADDR;
                end
            end
        end else if (i_dec) begin
            if (r_col != 7'd0) begin
                r_col  <= r_col - 7'd1;
                r_addr <= r_addr - ADDR_W'(1);
            end else if (r_row != 5'd0) begin
                r_row  <= r_row - 5'd1;
                r_col  <= c_LAST_COL;
                r_addr <= r_addr - ADDR_W'(1);
            end
        end else if (i_cr) begin
            r_col  <= '0;
            r_addr <= w_line_start;
        end else if (i_lf) begin
            r_col <= '0;
            if (!w_last_row) begin
                r_row  <= r_row + 5'd1;
                r_addr <= w_line_start + c_COLS_A;
            end else begin
                r_addr <= c_LAST_ROW_ADDR;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/vga_text_writer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | vga_text_writer : byte stream to text RAM with wrap, CR/LF, BS, scroll|
// | Build macro VGA_TEXT_CLEAR_ON_RESET_EN: blank the RAM after reset.   |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module vga_text_writer
    import vga_text_pkg::*;
#(
    parameter int COLS   = COLS_DEF,
    parameter int ROWS   = ROWS_DEF,
    parameter int ADDR_W = 12
) (
    input  logic              pclk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [7:0]        in_char,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,
    output logic [4:0]        cur_row,
    output logic [6:0]        cur_col,
    output logic              busy
);

    localparam logic [ADDR_W-1:0] c_COPY_LAST = ADDR_W'(COLS * (ROWS - 1) - 1);
    localparam logic [ADDR_W-1:0] c_LAST_ADDR = ADDR_W'(COLS * ROWS - 1);
    localparam logic [ADDR_W-1:0] c_COLS_A    = ADDR_W'(COLS);

    state_t            r_state;
    op_t               r_op;
    logic              r_ready;
    logic              r_we;
    logic              r_busy;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] r_idx;
    logic [7:0]        r_wdata;

    logic [ADDR_W-1:0] w_cur_addr;
    logic [ADDR_W-1:0] w_dec_addr;
    logic              w_scroll_req;
    logic              w_accept;
    logic              w_inc;
    logic              w_dec;
    logic              w_cr;
    logic              w_lf;
    logic              w_home;
    logic              w_bs_ok;

    assign w_accept = (r_state == ST_IDLE) && r_ready && in_valid;
    assign w_inc    = (r_state == ST_PUT) && (r_op == OP_INC);
    assign w_lf     = (r_state == ST_PUT) && (r_op == OP_LF);
    assign w_cr     = (r_state == ST_PUT) && (r_op == OP_CR);
    // Backspace moves the cursor first so the blanking write lands on the new cell.
    assign w_dec    = w_accept && (in_char == ASC_BS);
    assign w_bs_ok  = (cur_row != 5'd0) || (cur_col != 7'd0);

`ifdef VGA_TEXT_CLEAR_ON_RESET_EN
    logic r_cleared;
    assign w_home = (r_state == ST_CLR_ALL);
`else
    assign w_home = 1'b0;
`endif

    vga_text_cursor #(
        .COLS   (COLS),
        .ROWS   (ROWS),
        .ADDR_W (ADDR_W)
    ) u_cursor (
        .pclk         (pclk),
        .rst          (rst),
        .i_inc        (w_inc),
        .i_dec        (w_dec),
        .i_cr         (w_cr),
        .i_lf         (w_lf),
        .i_home       (w_home),
        .o_row        (cur_row),
        .o_col        (cur_col),
        .o_addr       (w_cur_addr),
        .o_dec_addr   (w_dec_addr),
        .o_scroll_req (w_scroll_req)
    );

    assign in_ready  = r_ready;
    assign mem_we    = r_we;
    assign mem_addr  = r_addr;
    assign busy      = r_busy;
    // RAM read data arrives during SCROLL_WR and is written straight back.
    assign mem_wdata = (r_state == ST_SCROLL_WR) ? mem_rdata : r_wdata;

    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_op    <= OP_NONE;
            r_ready <= 1'b0;
            r_we    <= 1'b0;
            r_busy  <= 1'b0;
            r_addr  <= '0;
            r_idx   <= '0;
            r_wdata <= '0;
`ifdef VGA_TEXT_CLEAR_ON_RESET_EN
            r_cleared <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
`ifdef VGA_TEXT_CLEAR_ON_RESET_EN
                    if (!r_cleared) begin
                        r_state <= ST_CLR_ALL;
                        r_we    <= 1'b1;
                        r_addr  <= '0;
                        r_wdata <= ASC_SPACE;
                        r_busy  <= 1'b1;
                    end else
`endif
                    if (w_accept) begin
                        r_ready <= 1'b0;
                        r_state <= ST_PUT;
                        r_op    <= OP_NONE;
                        if (is_printable(in_char)) begin
                            r_we    <= 1'b1;
                            r_addr  <= w_cur_addr;
                            r_wdata <= in_char;
                            r_op    <= OP_INC;
                        end else if (in_char == ASC_LF) begin
                            r_op <= OP_LF;
                        end else if (in_char == ASC_CR) begin
                            r_op <= OP_CR;
                        end else if ((in_char == ASC_BS) && w_bs_ok) begin
                            r_we    <= 1'b1;
                            r_addr  <= w_dec_addr;
                            r_wdata <= ASC_SPACE;
                        end
                    end else begin
                        r_ready <= 1'b1;
                    end
                end
                ST_PUT: begin
                    r_we <= 1'b0;
                    if (w_scroll_req) begin
                        r_state <= ST_SCROLL_RD;
                        r_busy  <= 1'b1;
                        r_idx   <= '0;
                        r_addr  <= c_COLS_A;
                    end else begin
                        r_state <= ST_IDLE;
                        r_ready <= 1'b1;
                    end
                end
                ST_SCROLL_RD: begin
                    r_state <= ST_SCROLL_WR;
                    r_we    <= 1'b1;
                    r_addr  <= r_idx;
                end
                ST_SCROLL_WR: begin
                    if (r_idx == c_COPY_LAST) begin
                        r_state <= ST_CLR_LINE;
                        r_addr  <= r_idx + ADDR_W'(1);
                        r_wdata <= ASC_SPACE;
                    end else begin
                        r_state <= ST_SCROLL_RD;
                        r_we    <= 1'b0;
                        r_idx   <= r_idx + ADDR_W'(1);
                        r_addr  <= r_idx + c_COLS_A + ADDR_W'(1);
                    end
                end
                ST_CLR_LINE: begin
                    if (r_addr == c_LAST_ADDR) begin
                        r_state <= ST_IDLE;
                        r_we    <= 1'b0;
                        r_busy  <= 1'b0;
                        r_ready <= 1'b1;
                    end else begin
                        r_addr <= r_addr + ADDR_W'(1);
                    end
                end
`ifdef VGA_TEXT_CLEAR_ON_RESET_EN
                ST_CLR_ALL: begin
                    if (r_addr == c_LAST_ADDR) begin
                        r_state   <= ST_IDLE;
                        r_we      <= 1'b0;
                        r_busy    <= 1'b0;
                        r_ready   <= 1'b1;
                        r_cleared <= 1'b1;
                    end else begin
                        r_addr <= r_addr + ADDR_W'(1);
                    end
                end
`endif
                default: begin
                    r_state <= ST_IDLE;
                    r_we    <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vga_text_writer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_vga_text_writer : scoreboard bench for vga_text_writer            |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module tb_vga_text_writer;

    localparam int COLS  = 80;
    localparam int ROWS  = 30;
    localparam int NCELL = COLS * ROWS;

    logic        pclk     = 1'b0;
    logic        rst      = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_char  = 8'h00;
    logic        in_ready;
    logic        mem_we;
    logic [11:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic [4:0]  cur_row;
    logic [6:0]  cur_col;
    logic        busy;

    logic        pre_we   = 1'b0;
    logic [11:0] pre_addr = 12'd0;
    logic [7:0]  pre_data = 8'd0;

    logic [7:0]  ram    [0:4095];
    logic [7:0]  shadow [0:NCELL-1];
    logic [19:0] exp_q  [$];

    int n_checks = 0;
    int n_errors = 0;
    int m_row    = 0;
    int m_col    = 0;

    vga_text_writer u_dut (
        .pclk      (pclk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_char   (in_char),
        .in_ready  (in_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .cur_row   (cur_row),
        .cur_col   (cur_col),
        .busy      (busy)
    );

    always #5 pclk = ~pclk;

    // Synchronous text RAM with a bench-side preload port.
    always @(posedge pclk) begin
        if (pre_we)
            ram[pre_addr] <= pre_data;
        else if (mem_we)
            ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    always @(negedge pclk) begin
        if (rst && mem_we) begin
            check("wr_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0)
                check("wr_addr_data", {12'd0, mem_addr, mem_wdata}, {12'd0, exp_q.pop_front()});
        end
    end

    task automatic push_wr(input int a, input logic [7:0] d);
        exp_q.push_back({12'(a), d});
        shadow[a] = d;
    endtask

    task automatic model_scroll();
        for (int i = 0; i < COLS * (ROWS - 1); i++)
            push_wr(i, shadow[i + COLS]);
        for (int j = COLS * (ROWS - 1); j < NCELL; j++)
            push_wr(j, 8'h20);
    endtask

    task automatic model_byte(input logic [7:0] b);
        if (b >= 8'h20 && b <= 8'h7E) begin
            push_wr(m_row * COLS + m_col, b);
            if (m_col == COLS - 1) begin
                m_col = 0;
                if (m_row == ROWS - 1) model_scroll();
                else m_row++;
            end else begin
                m_col++;
            end
        end else if (b == 8'h0A) begin
            m_col = 0;
            if (m_row == ROWS - 1) model_scroll();
            else m_row++;
        end else if (b == 8'h0D) begin
            m_col = 0;
        end else if (b == 8'h08) begin
            if (m_col > 0) begin
                m_col--;
                push_wr(m_row * COLS + m_col, 8'h20);
            end else if (m_row > 0) begin
                m_row--;
                m_col = COLS - 1;
                push_wr(m_row * COLS + m_col, 8'h20);
            end
        end
    endtask

    task automatic wait_ready(input string tag);
        int i;
        i = 0;
        @(negedge pclk);
        while (!in_ready && i < 6000) begin
            @(negedge pclk);
            i++;
        end
        check(tag, 32'(in_ready), 32'd1);
    endtask

    task automatic send_byte(input logic [7:0] b);
        wait_ready("ready_wait");
        check("cur_row", 32'(cur_row), 32'(m_row));
        check("cur_col", 32'(cur_col), 32'(m_col));
        model_byte(b);
        in_char  = b;
        in_valid = 1'b1;
        @(posedge pclk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic release_reset();
`ifdef VGA_TEXT_CLEAR_ON_RESET_EN
        for (int i = 0; i < NCELL; i++)
            push_wr(i, 8'h20);
`endif
        @(negedge pclk);
        rst = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: run did not finish, expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        int bad;

        for (int i = 0; i < NCELL; i++) begin
            @(negedge pclk);
            pre_we   = 1'b1;
            pre_addr = 12'(i);
            pre_data = 8'h30 + 8'(i % 10);
            shadow[i] = 8'h30 + 8'(i % 10);
        end
        @(negedge pclk);
        pre_we = 1'b0;

        check("rst_we",    32'(mem_we),    32'd0);
        check("rst_addr",  32'(mem_addr),  32'd0);
        check("rst_wdata", 32'(mem_wdata), 32'd0);
        check("rst_ready", 32'(in_ready),  32'd0);
        check("rst_busy",  32'(busy),      32'd0);
        check("rst_row",   32'(cur_row),   32'd0);
        check("rst_col",   32'(cur_col),   32'd0);

        release_reset();
`ifdef VGA_TEXT_CLEAR_ON_RESET_EN
        wait_ready("clear_all_done");
        check("clear_all_busy", 32'(busy), 32'd0);
`else
        @(negedge pclk);
        check("ready_after_rst", 32'(in_ready), 32'd1);
        check("ram_untouched", 32'(ram[NCELL-1]), 32'h39);
`endif

        send_byte(8'h08);
        check("bs00_ready_drop", 32'(in_ready), 32'd0);
        check("bs00_no_we", 32'(mem_we), 32'd0);
        @(posedge pclk);
        #1;
        check("bs00_ready_back", 32'(in_ready), 32'd1);

        send_byte(8'h41);
        check("a_we",    32'(mem_we),    32'd1);
        check("a_addr",  32'(mem_addr),  32'd0);
        check("a_wdata", 32'(mem_wdata), 32'h41);
        check("a_ready", 32'(in_ready),  32'd0);
        @(posedge pclk);
        #1;
        check("a_ready_back", 32'(in_ready), 32'd1);
        check("a_col", 32'(cur_col), 32'd1);

        send_byte(8'h0D);
        for (int i = 0; i < COLS; i++)
            send_byte(8'h21 + 8'(i % 90));
        wait_ready("row_ready");
        check("wrap_row", 32'(cur_row), 32'd1);
        check("wrap_col", 32'(cur_col), 32'd0);
        check("wrap_busy", 32'(busy), 32'd0);

        send_byte(8'h0A);
        send_byte(8'h0A);
        send_byte(8'h08);
        wait_ready("bs_ready");
        check("bs_row", 32'(cur_row), 32'd2);
        check("bs_col", 32'(cur_col), 32'd79);

        for (int i = 0; i < 27; i++)
            send_byte(8'h0A);
        send_byte(8'h07);
        wait_ready("pre_scroll_ready");
        for (int i = COLS; i < 2 * COLS; i++) begin
            @(negedge pclk);
            pre_we    = 1'b1;
            pre_addr  = 12'(i);
            pre_data  = 8'h42;
            shadow[i] = 8'h42;
        end
        @(negedge pclk);
        pre_we = 1'b0;

        send_byte(8'h0A);
        cnt = 0;
        bad = 0;
        for (int k = 0; k < 6000; k++) begin
            @(negedge pclk);
            if (busy) begin
                cnt++;
                if (in_ready) bad++;
            end else if (cnt > 0) begin
                break;
            end
        end
        check("scroll_busy_cycles", 32'(cnt), 32'd4720);
        check("scroll_ready_low", 32'(bad), 32'd0);
        check("scroll_ram0", 32'(ram[0]), 32'h42);
        check("scroll_ram79", 32'(ram[79]), 32'h42);
        bad = 0;
        for (int j = COLS * (ROWS - 1); j < NCELL; j++)
            if (ram[j] !== 8'h20) bad++;
        check("scroll_last_row_blank", 32'(bad), 32'd0);
        wait_ready("scroll_ready");
        check("scroll_row", 32'(cur_row), 32'd29);
        check("scroll_col", 32'(cur_col), 32'd0);

        send_byte(8'h0A);
        repeat (1000) @(posedge pclk);
        #2;
        rst = 1'b0;
        #1;
        check("arst_we",    32'(mem_we),   32'd0);
        check("arst_ready", 32'(in_ready), 32'd0);
        check("arst_busy",  32'(busy),     32'd0);
        check("arst_row",   32'(cur_row),  32'd0);
        check("arst_col",   32'(cur_col),  32'd0);
        check("arst_addr",  32'(mem_addr), 32'd0);
        exp_q.delete();
        m_row = 0;
        m_col = 0;
        repeat (3) @(negedge pclk);
        release_reset();

        send_byte(8'h5A);
        check("z_addr",  32'(mem_addr),  32'd0);
        check("z_wdata", 32'(mem_wdata), 32'h5A);
        wait_ready("final_ready");
        check("final_col", 32'(cur_col), 32'd1);
        repeat (5) @(negedge pclk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/vga_text_writer.md
Name: vga_text_writer

Overview:
Writer side of the VGA character buffer. Accepts a stream of ASCII bytes from the CPU/console over a valid/ready handshake and writes character codes into the dual-port text RAM at cursor-derived addresses. The scanout path reads that RAM and renders glyphs from it. The block handles cursor advance, line wrap, CR/LF, backspace and hardware scroll, so software only pushes bytes.

Parameters:
COLS, 80, characters per row
ROWS, 30, rows per screen
ADDR_W, 12, text-RAM address width; COLS*ROWS must be <= 2**ADDR_W

Ports:
pclk  in  1  pixel/system clock; all logic on rising edge
rst  in  1  asynchronous, active-low reset
in_valid  in  1  byte offered
in_char  in  8  ASCII byte
in_ready  out  1  block can accept a byte this cycle
mem_we  out  1  text-RAM write enable
mem_addr  out  ADDR_W  text-RAM address = row*COLS + col
mem_wdata  out  8  character code written
mem_rdata  in  8  text-RAM read data; synchronous, 1-cycle latency from mem_addr
cur_row  out  5  cursor row, 0..ROWS-1
cur_col  out  7  cursor column, 0..COLS-1
busy  out  1  scroll or clear in progress

Behaviour:
- Reset (rst low, async): state IDLE; cur_row=0, cur_col=0; mem_we=0, mem_addr=0, mem_wdata=0; in_ready=0; busy=0. Any operation in flight is abandoned immediately, with no partial write after reset.
- in_ready: registered. It is 1 only in IDLE, starting the first cycle after rst deasserts (subject to the optional feature). A byte transfers on a cycle with in_valid && in_ready. in_ready drops the next cycle and rises again when processing finishes.
- States: IDLE, PUT, SCROLL_RD, SCROLL_WR, CLR_LINE (plus CLR_ALL when the optional feature is enabled).
- Printable byte (0x20..0x7E):
  - PUT cycle: mem_we=1, address = cursor, data = byte.
  - Then col+1. If the old col was COLS-1: col=0 and row+1.
  - If row would exceed ROWS-1: go to SCROLL_RD; the cursor stays on row ROWS-1, col 0.
  - Otherwise return to IDLE. Throughput is 1 byte per 2 cycles.
- 0x0A (LF): col=0, row+1, scrolling as above. No RAM write.
- 0x0D (CR): col=0. No write.
- 0x08 (BS):
  - If col>0: col-1, then PUT writes 0x20 at the new position.
  - If col==0 and row>0: row-1, col=COLS-1, then write 0x20.
  - At (0,0): no change and no write.
- Any other byte is accepted and ignored.
- Scroll: for i in 0..COLS*(ROWS-1)-1:
  - SCROLL_RD presents address i+COLS with mem_we=0.
  - SCROLL_WR writes mem_rdata to address i.
  - Then CLR_LINE writes 0x20 to the COLS cells of row ROWS-1.
  - Total: 2*COLS*(ROWS-1)+COLS cycles; 4720 at the defaults. busy=1 throughout, in_ready=0.
- The address is kept as an incremental linear register; no runtime multiplier. mem_addr never exceeds COLS*ROWS-1.
- mem_we is never asserted outside PUT, SCROLL_WR, CLR_LINE and CLR_ALL.

Optional Feature:
VGA_TEXT_CLEAR_ON_RESET_EN
- Defined: after rst release the FSM enters CLR_ALL and writes 0x20 to addresses 0..COLS*ROWS-1, one per cycle, with busy=1. in_ready first rises the cycle after the last write.
- Undefined: no CLR_ALL state; IDLE and in_ready=1 from the first cycle after reset, and RAM contents are left untouched.

Decomposition:
- Package vga_text_pkg holds:
  - COLS/ROWS defaults
  - ASCII constants: ASC_LF=0x0A, ASC_CR=0x0D, ASC_BS=0x08, ASC_SPACE=0x20
  - the FSM state encoding
- One sub-module, vga_text_cursor: row/col/linear-address registers with inc, dec, cr, lf and home operations, plus a wrap/scroll-request flag.

Test Plan:
- Reset release, then "A" (0x41) -> next cycle mem_we=1, addr=0, wdata=0x41; then cur_col=1, in_ready high again 2 cycles after acceptance.
- 80 printable bytes from (0,0) -> last write at addr 79; cursor at (1,0); no scroll.
- LF at row 29 with row 1 preloaded to 0x42 -> busy for 4720 cycles; addr 0 reads 0x42; addresses 2320..2399 hold 0x20; cursor at (29,0).
- BS at (3,0) -> cursor (2,79); write 0x20 to addr 239. BS at (0,0) -> no write, cursor unchanged.
- rst low during scroll mid-copy -> mem_we=0 asynchronously; cursor (0,0); in_ready=0; no writes after release until IDLE.
- With VGA_TEXT_CLEAR_ON_RESET_EN defined -> 2400 consecutive writes of 0x20 to addr 0..2399, then in_ready=1.
